grey_sweep_ctrl: RTL and testbench
==================================

Name: grey_sweep_ctrl

Overview:
- Sequencer for the team's up/down grey-code counter datapath.
- Accepts sweep commands (start value, end value, step divider, mode) over a valid/ready handshake.
- Drives the binary count and its grey encoding toward the end value at a programmable rate.
- Signals completion, supports abort, and supports continuous ping-pong sweeping between the two endpoints.

Parameters:
- WIDTH, 4, counter width in bits for binary and grey.
- DIV_W, 8, width of the step-divider field.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_start  input  WIDTH  sweep start value (binary).
- cmd_end  input  WIDTH  sweep end value (binary).
- cmd_div  input  DIV_W  step every cmd_div+1 cycles.
- cmd_mode  input  1  0 = one-shot, 1 = ping-pong.
- abort  input  1  stop current sweep.
- binary  output  WIDTH  registered binary count.
- grey  output  WIDTH  binary ^ (binary >> 1), combinational from the binary register.
- updown  output  1  current direction; 1 = up, 0 = down.
- step  output  1  pulse in the cycle binary changes value.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, binary=0, grey=0, updown=1, step=0, busy=0, done=0, cmd_ready=1.
  - Prescaler and captured fields are cleared.
  - Reset mid-sweep discards the sweep with no done pulse.
- States:
  - IDLE: cmd_ready=1. cmd_valid=1 at edge N → capture start/end/div/mode; binary←cmd_start; updown←(cmd_end>=cmd_start); prescaler←0; go to RUN (or to DONE if cmd_start==cmd_end and mode=0). Values are visible after edge N.
  - RUN: busy=1, cmd_ready=0.
    - Prescaler increments each cycle.
    - When prescaler==div: prescaler←0; binary←binary±1 per updown; step=1 that cycle.
    - One-shot: the step that makes binary==end moves to DONE.
    - Ping-pong: on reaching end, swap the captured start/end, invert updown, stay in RUN. The first step of the reverse leg comes div+1 cycles later.
    - Ping-pong with start==end: stay in RUN, no steps, until abort.
  - DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0; next state IDLE. binary holds the end value.
- Timing:
  - First step of a sweep lands at edge N+div+1.
  - A one-shot sweep of k steps finishes at edge N+k(div+1); done is high in the following cycle.
- Wrap-around:
  - Direction always points toward end, so binary never wraps past 0 or 2^WIDTH−1.
  - Arithmetic is modulo 2^WIDTH but unreachable.
- abort:
  - abort=1 in RUN → IDLE at the next edge; binary and updown hold; no done; any step due that same edge is suppressed.
  - abort in IDLE or DONE is ignored.
  - abort and cmd_valid together in IDLE: the command is accepted.
- Outside IDLE: cmd_valid is ignored (cmd_ready=0); the command is not buffered.
- grey changes exactly one bit per step and never changes outside a step, load, or reset.

Optional Feature:
- Macro: GREY_CHECK_EN.
- When defined:
  - Adds a register holding the previous grey value.
  - Output grey_err (1 bit) is set sticky if a step cycle changes a popcount other than 1 bit of grey, or if grey changes in a non-step, non-load cycle.
  - Cleared only by reset.
- When undefined: the grey_err port still exists, tied to 0; no checker logic.

Test Plan:
- Reset: rst=0 for 2 cycles with cmd_valid=1 → binary=0000, grey=0000, updown=1, cmd_ready=1, busy=0, done=0; command not accepted.
- One-shot up: start=3, end=7, div=1, mode=0 → binary 3,4,5,6,7 every 2 cycles; grey 0010,0110,0111,0101,0100; done pulses once, 1 cycle after binary=7; then cmd_ready=1.
- One-shot down: start=12, end=9, div=0 → binary 12,11,10,9 on consecutive cycles; updown=0; grey 1010,1110,1111,1101; done once.
- Ping-pong: start=0, end=2, div=0, mode=1 → binary 0,1,2,1,0,1,2…; updown toggles at each endpoint; no done.
- Abort: abort asserted at binary=5 during 3→10 sweep → IDLE next edge; binary holds 5; no done; new command accepted the following cycle.
- start==end (6,6) mode=0 → DONE the cycle after accept; done=1, binary=6, zero step pulses. With GREY_CHECK_EN, all scenarios give grey_err=0.

Source files
------------

// File: rtl/grey_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// grey_sweep_ctrl
//
// Purpose:
//   Sequencer for an up/down grey-code counter. A sweep command (start, end,
//   step divider, mode) is accepted over a valid/ready handshake. The binary
//   count then moves one step toward the end value every cmd_div+1 cycles.
//   The grey encoding of the count is derived from the binary register.
//   A one-shot sweep ends with a single-cycle done pulse. A ping-pong sweep
//   bounces between the two endpoints until it is aborted.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low (0 = reset)
//   cmd_valid  in   command present
//   cmd_ready  out  controller idle and able to take a command
//   cmd_start  in   [WIDTH] sweep start value (binary)
//   cmd_end    in   [WIDTH] sweep end value (binary)
//   cmd_div    in   [DIV_W] step every cmd_div+1 cycles
//   cmd_mode   in   0 = one-shot, 1 = ping-pong
//   abort      in   stop the current sweep (RUN only)
//   binary     out  [WIDTH] registered binary count
//   grey       out  [WIDTH] binary ^ (binary >> 1)
//   updown     out  current direction, 1 = up
//   step       out  high in the cycle whose closing edge changes binary
//   busy       out  high while sweeping
//   done       out  one-cycle completion pulse (one-shot only)
//   grey_err   out  sticky grey-code integrity flag (0 unless checker built)
//
// Build option:
//   GREY_CHECK_EN - when defined, adds a checker that watches grey and sets
//   grey_err if a step changes anything other than exactly one bit, or if grey
//   moves in a cycle that is neither a step nor a command load. When it is not
//   defined, grey_err is tied to 0.
// -----------------------------------------------------------------------------
module grey_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             cmd_mode,
    input  logic             abort,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] grey,
    output logic             updown,
    output logic             step,
    output logic             busy,
    output logic             done,
    output logic             grey_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] binary_q, binary_d;
    logic             updown_q, updown_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;

    logic             step_c;
    logic [WIDTH-1:0] stepped_bin;

    // Value the count takes if a step happens this cycle.
    assign stepped_bin = updown_q ? (binary_q + WIDTH'(1)) : (binary_q - WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            binary_q <= '0;
            updown_q <= 1'b1;
            presc_q  <= '0;
            start_q  <= '0;
            end_q    <= '0;
            div_q    <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            binary_q <= binary_d;
            updown_q <= updown_d;
            presc_q  <= presc_d;
            start_q  <= start_d;
            end_q    <= end_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        binary_d = binary_q;
        updown_d = updown_q;
        presc_d  = presc_q;
        start_d  = start_q;
        end_d    = end_q;
        div_d    = div_q;
        mode_d   = mode_q;
        step_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort has no effect here; a pending command always wins.
                if (cmd_valid) begin
                    start_d  = cmd_start;
                    end_d    = cmd_end;
                    div_d    = cmd_div;
                    mode_d   = cmd_mode;
                    binary_d = cmd_start;
                    updown_d = (cmd_end >= cmd_start);
                    presc_d  = '0;
                    if ((cmd_start == cmd_end) && !cmd_mode) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    // Count and direction freeze where they are; a step that
                    // would have landed on this edge is dropped.
                    state_d = S_IDLE;
                end else if (binary_q != end_q) begin
                    // binary == end in RUN only happens for a ping-pong sweep
                    // with equal endpoints, which idles until aborted.
                    if (presc_q == div_q) begin
                        presc_d  = '0;
                        step_c   = 1'b1;
                        binary_d = stepped_bin;
                        if (stepped_bin == end_q) begin
                            if (mode_q) begin
                                // Reverse leg: swap endpoints, flip direction.
                                start_d  = end_q;
                                end_d    = start_q;
                                updown_d = ~updown_q;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign binary    = binary_q;
    assign grey      = binary_q ^ (binary_q >> 1);
    assign updown    = updown_q;
    assign step      = step_c;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign cmd_ready = (state_q == S_IDLE);

`ifdef GREY_CHECK_EN
    logic [WIDTH-1:0] grey_prev_q;
    logic             step_prev_q;
    logic             load_prev_q;
    logic             grey_err_q;
    logic [WIDTH-1:0] grey_diff;

    // Difference between this cycle's grey and last cycle's. A step or load
    // in the previous cycle is what explains a change seen now.
    assign grey_diff = grey ^ grey_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            grey_prev_q <= '0;
            step_prev_q <= 1'b0;
            load_prev_q <= 1'b0;
            grey_err_q  <= 1'b0;
        end else begin
            grey_prev_q <= grey;
            step_prev_q <= step_c;
            load_prev_q <= (state_q == S_IDLE) && cmd_valid;
            if ((step_prev_q && ($countones(grey_diff) != 1)) ||
                (!step_prev_q && !load_prev_q && (grey_diff != '0))) begin
                grey_err_q <= 1'b1;
            end
        end
    end

    assign grey_err = grey_err_q;
`else
    assign grey_err = 1'b0;
`endif

endmodule

// File: tb/tb_grey_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grey_sweep_ctrl
//
// Directed bench for grey_sweep_ctrl. Inputs are driven and outputs sampled
// on the falling edge. Time index t counts falling edges after the accepting
// rising edge N, so t=1 is the first cycle after the command was loaded.
// -----------------------------------------------------------------------------
module tb_grey_sweep_ctrl;

    localparam int WIDTH = 4;
    localparam int DIV_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_end;
    logic [DIV_W-1:0] cmd_div;
    logic             cmd_mode;
    logic             abort;
    logic [WIDTH-1:0] binary;
    logic [WIDTH-1:0] grey;
    logic             updown;
    logic             step;
    logic             busy;
    logic             done;
    logic             grey_err;

    int n_checks = 0;
    int n_errors = 0;

    grey_sweep_ctrl #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .cmd_div   (cmd_div),
        .cmd_mode  (cmd_mode),
        .abort     (abort),
        .binary    (binary),
        .grey      (grey),
        .updown    (updown),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .grey_err  (grey_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a command at the current falling edge; return at t=1.
    task automatic send_cmd(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e,
                            input logic [DIV_W-1:0] d, input logic m);
        $display("cmd: start=%0d end=%0d div=%0d mode=%0d", s, e, d, m);
        cmd_start = s;
        cmd_end   = e;
        cmd_div   = d;
        cmd_mode  = m;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] up_grey [5];
    logic [WIDTH-1:0] dn_grey [4];
    logic [WIDTH-1:0] pp_bin  [8];
    logic             pp_dir  [8];

    initial begin
        up_grey = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};
        dn_grey = '{4'b1010, 4'b1110, 4'b1111, 4'b1101};
        pp_bin  = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd1};
        pp_dir  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // ---- reset held two edges with a command present ----
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_start = 4'd5;
        cmd_end   = 4'd9;
        cmd_div   = 8'd0;
        cmd_mode  = 1'b0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset: binary=%0d ready=%0d", binary, cmd_ready);
        check_val("rst_binary", 32'(binary), 32'd0);
        check_val("rst_grey", 32'(grey), 32'd0);
        check_val("rst_updown", 32'(updown), 32'd1);
        check_val("rst_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_step", 32'(step), 32'd0);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_val("post_rst_binary", 32'(binary), 32'd0);
        check_val("post_rst_busy", 32'(busy), 32'd0);

        // ---- one-shot up 3 -> 7, div=1 ----
        send_cmd(4'd3, 4'd7, 8'd1, 1'b0);
        for (int t = 1; t <= 9; t++) begin
            check_val($sformatf("up_bin_t%0d", t), 32'(binary), 32'(3 + (t - 1) / 2));
            check_val($sformatf("up_grey_t%0d", t), 32'(grey), 32'(up_grey[(t - 1) / 2]));
            check_val($sformatf("up_step_t%0d", t), 32'(step), 32'((t % 2) == 0));
            check_val($sformatf("up_busy_t%0d", t), 32'(busy), 32'(t < 9));
            check_val($sformatf("up_done_t%0d", t), 32'(done), 32'(t == 9));
            check_val($sformatf("up_dir_t%0d", t), 32'(updown), 32'd1);
            @(negedge clk);
        end
        check_val("up_done_after", 32'(done), 32'd0);
        check_val("up_ready_after", 32'(cmd_ready), 32'd1);
        check_val("up_bin_after", 32'(binary), 32'd7);

        // ---- one-shot down 12 -> 9, div=0 ----
        send_cmd(4'd12, 4'd9, 8'd0, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            check_val($sformatf("dn_bin_t%0d", t), 32'(binary), 32'(12 - (t - 1)));
            check_val($sformatf("dn_grey_t%0d", t), 32'(grey), 32'(dn_grey[t - 1]));
            check_val($sformatf("dn_dir_t%0d", t), 32'(updown), 32'd0);
            check_val($sformatf("dn_step_t%0d", t), 32'(step), 32'(t < 4));
            check_val($sformatf("dn_done_t%0d", t), 32'(done), 32'(t == 4));
            @(negedge clk);
        end
        check_val("dn_done_after", 32'(done), 32'd0);
        check_val("dn_ready_after", 32'(cmd_ready), 32'd1);

        // ---- ping-pong 0 <-> 2, div=0; a command offered mid-sweep is ignored ----
        send_cmd(4'd0, 4'd2, 8'd0, 1'b1);
        for (int t = 1; t <= 8; t++) begin
            check_val($sformatf("pp_bin_t%0d", t), 32'(binary), 32'(pp_bin[t - 1]));
            check_val($sformatf("pp_dir_t%0d", t), 32'(updown), 32'(pp_dir[t - 1]));
            check_val($sformatf("pp_done_t%0d", t), 32'(done), 32'd0);
            check_val($sformatf("pp_busy_t%0d", t), 32'(busy), 32'd1);
            check_val($sformatf("pp_ready_t%0d", t), 32'(cmd_ready), 32'd0);
            if (t == 1) begin
                cmd_valid = 1'b1;
                cmd_start = 4'd9;
                cmd_end   = 4'd15;
            end
            if (t < 8) @(negedge clk);
        end
        // abort at t=8 (binary=1, heading down)
        cmd_valid = 1'b0;
        abort     = 1'b1;
        #1;
        check_val("pp_abort_step", 32'(step), 32'd0);
        @(negedge clk);
        $display("pp abort: binary=%0d busy=%0d", binary, busy);
        check_val("pp_abort_busy", 32'(busy), 32'd0);
        check_val("pp_abort_bin", 32'(binary), 32'd1);
        check_val("pp_abort_dir", 32'(updown), 32'd0);
        check_val("pp_abort_done", 32'(done), 32'd0);
        check_val("pp_abort_ready", 32'(cmd_ready), 32'd1);
        abort = 1'b0;

        // ---- abort at binary=5 during 3 -> 10 ----
        send_cmd(4'd3, 4'd10, 8'd0, 1'b0);
        for (int t = 1; t <= 3; t++) begin
            check_val($sformatf("ab_bin_t%0d", t), 32'(binary), 32'(2 + t));
            if (t < 3) @(negedge clk);
        end
        abort = 1'b1;
        #1;
        check_val("ab_step_suppressed", 32'(step), 32'd0);
        @(negedge clk);
        $display("abort: binary=%0d busy=%0d", binary, busy);
        check_val("ab_bin_hold", 32'(binary), 32'd5);
        check_val("ab_busy", 32'(busy), 32'd0);
        check_val("ab_done", 32'(done), 32'd0);
        check_val("ab_ready", 32'(cmd_ready), 32'd1);
        check_val("ab_dir", 32'(updown), 32'd1);

        // ---- start==end one-shot, accepted while abort is still high ----
        send_cmd(4'd6, 4'd6, 8'd3, 1'b0);
        check_val("eq_done", 32'(done), 32'd1);
        check_val("eq_bin", 32'(binary), 32'd6);
        check_val("eq_step", 32'(step), 32'd0);
        check_val("eq_busy", 32'(busy), 32'd0);
        check_val("eq_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check_val("eq_done_after", 32'(done), 32'd0);
        check_val("eq_ready_after", 32'(cmd_ready), 32'd1);
        check_val("eq_bin_after", 32'(binary), 32'd6);

        // ---- grey checker (tied low when not built) ----
        check_val("grey_err", 32'(grey_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
